// File: rtl/frame_pingpong_buffer.sv
// Double-buffered binary frame assembler: packed pixel words fill one bank
// while the consumer reads the other through a valid/ack handshake.
module frame_pingpong_buffer #(
  parameter  int IMG_WIDTH  = 30,
  parameter  int IMG_HEIGHT = 30,
  parameter  int DATA_W     = 8,
  localparam int TOTAL_BITS = IMG_WIDTH * IMG_HEIGHT,
  localparam int WORDS      = (TOTAL_BITS + DATA_W - 1) / DATA_W,
  localparam int ADDR_W     = ($clog2(WORDS + 1) > 1) ? $clog2(WORDS + 1) : 1,
  localparam int OUT_W      = WORDS * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic [OUT_W-1:0]  img_out,
  output logic [7:0]        frame_count,
  output logic              overrun
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  localparam logic [OUT_W-1:0]  PAD_MASK  = {OUT_W{1'b1}} >> (OUT_W - TOTAL_BITS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  bank_state_t      status [2];
  logic [OUT_W-1:0] bank_data [2];
  logic             wb_sel;
  logic             rb_sel;

  logic write_open;
  logic accept;
  logic release_bank;

  assign write_open   = (status[wb_sel] != FULL);
  assign accept       = in_valid && write_open;
  assign release_bank = frame_ack && (status[rb_sel] == FULL);

  // Outputs are forced to their idle values while reset is held.
  assign in_ready    = rst || write_open;
  assign frame_valid = !rst && (status[rb_sel] == FULL);
  assign overrun     = !rst && in_valid && !write_open;
  assign img_out     = rst ? '0 : (bank_data[rb_sel] & PAD_MASK);

  always_ff @(posedge clk) begin
    if (rst) begin
      status[0]    <= EMPTY;
      status[1]    <= EMPTY;
      wb_sel       <= 1'b0;
      rb_sel       <= 1'b0;
      wr_addr      <= '0;
      frame_count  <= '0;
      bank_data[0] <= '0;
      bank_data[1] <= '0;
    end else if (clear) begin
      status[0]   <= EMPTY;
      status[1]   <= EMPTY;
      wb_sel      <= 1'b0;
      rb_sel      <= 1'b0;
      wr_addr     <= '0;
      frame_count <= '0;
    end else begin
      // A write bank is never FULL when accepting, so it cannot be the bank being released.
      if (accept) begin
        bank_data[wb_sel][int'(wr_addr) * DATA_W +: DATA_W] <= in_data;
        if (wr_addr == LAST_ADDR) begin
          status[wb_sel] <= FULL;
          wr_addr        <= '0;
          wb_sel         <= ~wb_sel;
          frame_count    <= frame_count + 8'd1;
        end else begin
          status[wb_sel] <= FILLING;
          wr_addr        <= wr_addr + ADDR_W'(1);
        end
      end
      if (release_bank) begin
        status[rb_sel] <= EMPTY;
        rb_sel         <= ~rb_sel;
      end
    end
  end

endmodule
